// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the Avalon-ST to on-chip RAM frame loader.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    PACK,
    WRITE,
    DRAIN,
    DONE
  } state_t;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int LANE_W = $clog2(LANES);

  function automatic logic [LANE_W:0] lane_count(input logic [LANES-1:0] be);
    lane_count = '0;
    for (int i = 0; i < LANES; i++) lane_count += {{LANE_W{1'b0}}, be[i]};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: lane index, word accumulator and byteenable.
module byte_packer
  import ram_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      push_last,
  input  logic [BYTE_W-1:0]         byte_in,
  output logic [LANES*BYTE_W-1:0]   word_nxt,
  output logic [LANES-1:0]          be_nxt,
  output logic                      full,
  output logic                      last
);

  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [LANES*BYTE_W-1:0] word_q, word_d;
  logic [LANES-1:0]        be_q, be_d;
  logic                    last_q, last_d;

  always_comb begin
    lane_d = clear ? '0 : lane_q;
    word_d = clear ? '0 : word_q;
    be_d   = clear ? '0 : be_q;
    last_d = clear ? 1'b0 : last_q;
    if (push) begin
      word_d[int'(lane_d)*BYTE_W +: BYTE_W] = byte_in;
      be_d[lane_d] = 1'b1;
      last_d       = push_last;
      lane_d       = lane_d + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
      last_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
      last_q <= last_d;
    end
  end

  // A push while full is true completes the word.
  assign full     = (lane_q == LANE_W'(LANES - 1));
  assign last     = last_q;
  assign word_nxt = word_d;
  assign be_nxt   = be_d;

endmodule

// File: rtl/ram_frame_loader.sv
// Avalon-MM write master: packs a byte stream frame into 32-bit RAM words from address 0.
module ram_frame_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_bytes,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic        xfer, pk_clear, pk_push, pk_full, pk_last;
  logic [31:0] pk_word_nxt;
  logic [3:0]  pk_be_nxt;

  assign xfer = in_valid & ready_q;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .push      (pk_push),
    .push_last (in_eop),
    .byte_in   (in_data),
    .word_nxt  (pk_word_nxt),
    .be_nxt    (pk_be_nxt),
    .full      (pk_full),
    .last      (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bytes_d  = bytes_q;
    ovf_d    = ovf_q;
    pk_clear = 1'b0;
    pk_push  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = WAIT_SOP;
        addr_d   = '0;
        bytes_d  = '0;
        ovf_d    = 1'b0;
        pk_clear = 1'b1;
      end
      WAIT_SOP: if (xfer && in_sop) begin
        pk_push = 1'b1;
        state_d = in_eop ? WRITE : PACK;
      end
      PACK: if (xfer) begin
        pk_push = 1'b1;
        if (in_eop || pk_full) state_d = WRITE;
      end
      WRITE: begin
        // be_q holds exactly the lanes being written this cycle.
        pk_clear = 1'b1;
        bytes_d  = bytes_q + CNT_W'(lane_count(be_q));
        if (pk_last) begin
          state_d = DONE;
        end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
          ovf_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = PACK;
        end
      end
      DRAIN: if (xfer && in_eop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == WAIT_SOP) || (state_d == PACK) || (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    wr_d    = (state_d == WRITE);
    wdata_d = wr_d ? pk_word_nxt : '0;
    be_d    = wr_d ? pk_be_nxt : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bytes_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bytes_q <= bytes_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign in_ready       = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign frame_bytes    = bytes_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = wr_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_ram_frame_loader.sv
// Directed bench for ram_frame_loader with a byte-lane RAM model and a write log.
module tb_ram_frame_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid, in_sop, in_eop;
  logic              in_ready, busy, done, overflow;
  logic [CNT_W-1:0]  frame_bytes;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [3:0]        wb_q[$];
  logic [31:0]       ram [DEPTH];
  int                waits_log [32];

  ram_frame_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .frame_bytes    (frame_bytes),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write && mem_chipselect) begin
      wa_q.push_back(mem_address);
      wd_q.push_back(mem_writedata);
      wb_q.push_back(mem_byteenable);
      for (int l = 0; l < 4; l++)
        if (mem_byteenable[l]) ram[mem_address][8*l +: 8] = mem_writedata[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic sop, input logic eop, output int waits);
    in_data = b; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) chk("send_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      send(base + 8'(i), i == 0, i == n - 1, w);
      waits_log[i] = w;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    logic [31:0] oa, od, ob;
    oa = (i < wa_q.size()) ? {30'b0, wa_q[i]} : 'x;
    od = (i < wd_q.size()) ? wd_q[i] : 'x;
    ob = (i < wb_q.size()) ? {28'b0, wb_q[i]} : 'x;
    chk($sformatf("%s_w%0d_addr", tag, i), oa, {30'b0, a});
    chk($sformatf("%s_w%0d_data", tag, i), od, d);
    chk($sformatf("%s_w%0d_be", tag, i), ob, {28'b0, be});
  endtask

  initial begin
    int w;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    reset = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_chipselect", {31'b0, mem_chipselect}, 0);
    chk("rst_clken", {31'b0, mem_clken}, 1);
    chk("rst_frame_bytes", {27'b0, frame_bytes}, 0);
    chk("rst_wdata", mem_writedata, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: exact-fit 16-byte frame
    clear_log();
    start_pulse();
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_in_ready", {31'b0, in_ready}, 1);
    send_frame(8'h00, 16);
    wait_done("t1");
    chk("t1_nwr", wa_q.size(), 4);
    chk_wr("t1", 0, 2'd0, 32'h03020100, 4'hF);
    chk_wr("t1", 1, 2'd1, 32'h07060504, 4'hF);
    chk_wr("t1", 2, 2'd2, 32'h0B0A0908, 4'hF);
    chk_wr("t1", 3, 2'd3, 32'h0F0E0D0C, 4'hF);
    chk("t1_frame_bytes", {27'b0, frame_bytes}, 16);
    chk("t1_overflow", {31'b0, overflow}, 0);

    // 2: partial final word
    clear_log();
    start_pulse();
    send_frame(8'hA0, 6);
    wait_done("t2");
    chk("t2_nwr", wa_q.size(), 2);
    chk_wr("t2", 0, 2'd0, 32'hA3A2A1A0, 4'hF);
    chk_wr("t2", 1, 2'd1, 32'h0000A5A4, 4'h3);
    chk("t2_frame_bytes", {27'b0, frame_bytes}, 6);
    chk("t2_ram2_kept", ram[2], 32'h0B0A0908);

    // 3: 20-byte frame overflows, tail drained
    clear_log();
    start_pulse();
    send_frame(8'h30, 20);
    chk("t3_drain_wait17", waits_log[17], 0);
    chk("t3_drain_wait19", waits_log[19], 0);
    wait_done("t3");
    chk("t3_nwr", wa_q.size(), 4);
    chk_wr("t3", 3, 2'd3, 32'h3F3E3D3C, 4'hF);
    chk("t3_overflow", {31'b0, overflow}, 1);
    chk("t3_frame_bytes", {27'b0, frame_bytes}, 16);

    // 4: leading non-sop bytes dropped
    clear_log();
    start_pulse();
    chk("t4_overflow_cleared", {31'b0, overflow}, 0);
    send(8'hEE, 1'b0, 1'b0, w);
    send(8'hEF, 1'b0, 1'b0, w);
    send(8'hF0, 1'b0, 1'b1, w);
    send_frame(8'h11, 4);
    wait_done("t4");
    chk("t4_nwr", wa_q.size(), 1);
    chk_wr("t4", 0, 2'd0, 32'h14131211, 4'hF);
    chk("t4_frame_bytes", {27'b0, frame_bytes}, 4);

    // single-byte frame
    clear_log();
    start_pulse();
    send(8'h5A, 1'b1, 1'b1, w);
    wait_done("t1b");
    chk("t1b_nwr", wa_q.size(), 1);
    chk_wr("t1b", 0, 2'd0, 32'h0000005A, 4'h1);
    chk("t1b_frame_bytes", {27'b0, frame_bytes}, 1);

    // 5: valid gaps and an ignored mid-frame start
    clear_log();
    start_pulse();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 5) start_pulse();
      send(8'h60 + 8'(i), i == 0, i == 9, w);
    end
    wait_done("t5");
    repeat (3) @(negedge clk);
    chk("t5_busy_idle", {31'b0, busy}, 0);
    chk("t5_nwr", wa_q.size(), 3);
    chk_wr("t5", 0, 2'd0, 32'h63626160, 4'hF);
    chk_wr("t5", 1, 2'd1, 32'h67666564, 4'hF);
    chk_wr("t5", 2, 2'd2, 32'h00006968, 4'h3);
    chk("t5_frame_bytes", {27'b0, frame_bytes}, 10);

    // 6: asynchronous reset mid-frame, then a fresh frame
    clear_log();
    start_pulse();
    send(8'h77, 1'b1, 1'b0, w);
    send(8'h78, 1'b0, 1'b0, w);
    chk("t6_pack_ready", {31'b0, in_ready}, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_mem_write", {31'b0, mem_write}, 0);
    chk("t6_rst_busy", {31'b0, busy}, 0);
    chk("t6_rst_in_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_pulse();
    send_frame(8'h21, 4);
    wait_done("t6");
    chk("t6_nwr", wa_q.size(), 1);
    chk_wr("t6", 0, 2'd0, 32'h24232221, 4'hF);
    chk("t6_frame_bytes", {27'b0, frame_bytes}, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
